// File: rtl/rtc_clock_set.sv
`default_nettype none
// ============================================================================
// rtc_clock_set : settable HH:MM:SS real-time clock with BCD display feed.
// Optional alarm feature is built when the ALARM_EN macro is defined.
// Revision: 1.0
// ============================================================================
module rtc_clock_set #(
  parameter int CLK_HZ     = 100000000,
  parameter int RESET_HOUR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  key,
  output logic [15:0] seg_data,
  output logic [23:0] time_bcd,
  output logic        tick_1s,
  output logic        set_mode,
  output logic        pm,
  output logic        alarm
);

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] tens;
    tens = v / 6'd10;
    return {4'(tens), 4'(v - tens * 6'd10)};
  endfunction

  function automatic logic [5:0] adj(input logic [5:0] v, input logic [5:0] top,
                                     input logic up, input logic dn);
    if (up && !dn) return (v == top) ? 6'd0 : v + 6'd1;
    if (dn && !up) return (v == 6'd0) ? top : v - 6'd1;
    return v;
  endfunction

  localparam int              c_pw         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [c_pw-1:0] c_presc_max  = c_pw'(CLK_HZ - 1);
  localparam logic [c_pw-1:0] c_blink_half = c_pw'(CLK_HZ / 2);
  localparam logic [5:0]      c_rst_hour   = 6'(RESET_HOUR);
  localparam logic [7:0]      c_rst_hbcd   = to_bcd(6'(RESET_HOUR));
  localparam logic            c_rst_pm     = (RESET_HOUR >= 12);

  localparam logic [2:0] c_s_run  = 3'd0;
  localparam logic [2:0] c_s_hour = 3'd1;
  localparam logic [2:0] c_s_min  = 3'd2;
  localparam logic [2:0] c_s_sec  = 3'd3;
`ifdef ALARM_EN
  localparam logic [2:0] c_s_ahour = 3'd4;
  localparam logic [2:0] c_s_amin  = 3'd5;
`endif

  logic [4:0]      r_key_s1, r_key_s2, r_key_d;
  logic [4:0]      w_key_rise;
  logic            w_inc, w_dec;
  logic [2:0]      r_state, w_state_nxt;
  logic            w_sel_hour, w_sel_min, w_sel_sec, w_sel_ahour, w_sel_amin;
  logic [c_pw-1:0] r_presc, r_blink;
  logic [5:0]      r_sec, r_min, r_hour;
  logic [5:0]      w_tk_sec, w_tk_min, w_tk_hour;
  logic            r_page, r_fmt12;
  logic [5:0]      w_disp_hour;
  logic [7:0]      w_hi, w_lo;
  logic            w_hi_sel, w_lo_sel, w_blank;
  logic [15:0]     w_seg;

  // Two-flop synchroniser plus a delay stage for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_s1 <= '0;
      r_key_s2 <= '0;
      r_key_d  <= '0;
    end else begin
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;
      r_key_d  <= r_key_s2;
    end
  end

  assign w_key_rise = r_key_s2 & ~r_key_d;
  assign w_inc      = w_key_rise[2] & ~w_key_rise[3] & ~w_key_rise[0];
  assign w_dec      = w_key_rise[3] & ~w_key_rise[2] & ~w_key_rise[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_s_run;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_key_rise[0]) begin
      case (r_state)
        c_s_run:   w_state_nxt = c_s_hour;
        c_s_hour:  w_state_nxt = c_s_min;
        c_s_min:   w_state_nxt = c_s_sec;
`ifdef ALARM_EN
        c_s_sec:   w_state_nxt = c_s_ahour;
        c_s_ahour: w_state_nxt = c_s_amin;
`endif
        default:   w_state_nxt = c_s_run;
      endcase
    end
  end

  always_comb begin
    set_mode    = (r_state != c_s_run);
    tick_1s     = (r_state == c_s_run) && (r_presc == c_presc_max);
    w_sel_hour  = (r_state == c_s_hour);
    w_sel_min   = (r_state == c_s_min);
    w_sel_sec   = (r_state == c_s_sec);
`ifdef ALARM_EN
    w_sel_ahour = (r_state == c_s_ahour);
    w_sel_amin  = (r_state == c_s_amin);
`else
    w_sel_ahour = 1'b0;
    w_sel_amin  = 1'b0;
`endif
  end

  // Prescaler frozen at zero while editing so RUN re-entry starts a full second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_blink <= '0;
    end else begin
      r_presc <= (set_mode || r_presc == c_presc_max) ? '0 : r_presc + 1'b1;
      r_blink <= (!set_mode || r_blink == c_presc_max) ? '0 : r_blink + 1'b1;
    end
  end

  assign w_tk_sec  = adj(r_sec, 6'd59, 1'b1, 1'b0);
  assign w_tk_min  = (r_sec == 6'd59) ? adj(r_min, 6'd59, 1'b1, 1'b0) : r_min;
  assign w_tk_hour = (r_sec == 6'd59 && r_min == 6'd59) ?
                     adj(r_hour, 6'd23, 1'b1, 1'b0) : r_hour;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec  <= 6'd0;
      r_min  <= 6'd0;
      r_hour <= c_rst_hour;
    end else if (tick_1s) begin
      r_sec  <= w_tk_sec;
      r_min  <= w_tk_min;
      r_hour <= w_tk_hour;
    end else begin
      if (w_sel_hour) r_hour <= adj(r_hour, 6'd23, w_inc, w_dec);
      if (w_sel_min)  r_min  <= adj(r_min,  6'd59, w_inc, w_dec);
      if (w_sel_sec)  r_sec  <= adj(r_sec,  6'd59, w_inc, w_dec);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_page  <= 1'b0;
      r_fmt12 <= 1'b0;
    end else begin
      r_page  <= r_page ^ w_key_rise[1];
      r_fmt12 <= r_fmt12 ^ w_key_rise[4];
    end
  end

`ifdef ALARM_EN
  logic [5:0] r_ahour, r_amin, r_alarm_cnt;
  logic       r_alarm, w_alarm_hit;

  assign w_alarm_hit = tick_1s && (w_tk_sec == 6'd0) &&
                       (w_tk_min == r_amin) && (w_tk_hour == r_ahour);

  // Any key edge silences the alarm; otherwise it lasts 60 ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ahour     <= 6'd0;
      r_amin      <= 6'd0;
      r_alarm     <= 1'b0;
      r_alarm_cnt <= 6'd0;
    end else begin
      if (w_sel_ahour) r_ahour <= adj(r_ahour, 6'd23, w_inc, w_dec);
      if (w_sel_amin)  r_amin  <= adj(r_amin,  6'd59, w_inc, w_dec);
      if (|w_key_rise) begin
        r_alarm <= 1'b0;
      end else if (w_alarm_hit) begin
        r_alarm     <= 1'b1;
        r_alarm_cnt <= 6'd0;
      end else if (r_alarm && tick_1s) begin
        if (r_alarm_cnt == 6'd59) r_alarm <= 1'b0;
        r_alarm_cnt <= r_alarm_cnt + 6'd1;
      end
    end
  end

  assign alarm = r_alarm;
`else
  assign alarm = 1'b0;
`endif

  always_comb begin
    if (!r_fmt12)              w_disp_hour = r_hour;
    else if (r_hour == 6'd0)   w_disp_hour = 6'd12;
    else if (r_hour > 6'd12)   w_disp_hour = r_hour - 6'd12;
    else                       w_disp_hour = r_hour;
  end

  always_comb begin
    w_blank = set_mode && (r_blink >= c_blink_half);
    if (!r_page) begin
      w_hi     = to_bcd(w_disp_hour);
      w_lo     = to_bcd(r_min);
      w_hi_sel = w_sel_hour;
      w_lo_sel = w_sel_min;
    end else begin
      w_hi     = to_bcd(r_min);
      w_lo     = to_bcd(r_sec);
      w_hi_sel = w_sel_min;
      w_lo_sel = w_sel_sec;
    end
`ifdef ALARM_EN
    if (w_sel_ahour || w_sel_amin) begin
      w_hi     = to_bcd(r_ahour);
      w_lo     = to_bcd(r_amin);
      w_hi_sel = w_sel_ahour;
      w_lo_sel = w_sel_amin;
    end
`endif
    w_seg = {(w_blank && w_hi_sel) ? 8'hFF : w_hi,
             (w_blank && w_lo_sel) ? 8'hFF : w_lo};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_data <= {c_rst_hbcd, 8'h00};
      time_bcd <= {c_rst_hbcd, 16'h0000};
      pm       <= c_rst_pm;
    end else begin
      seg_data <= w_seg;
      time_bcd <= {to_bcd(r_hour), to_bcd(r_min), to_bcd(r_sec)};
      pm       <= (r_hour >= 6'd12);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtc_clock_set.sv
`default_nettype none
// ============================================================================
// tb_rtc_clock_set : scoreboard bench for rtc_clock_set at CLK_HZ = 10.
// Revision: 1.0
// ============================================================================
module tb_rtc_clock_set;

  localparam int         c_clk_hz = 10;
  localparam logic [4:0] c_k_mode = 5'b00001;
  localparam logic [4:0] c_k_page = 5'b00010;
  localparam logic [4:0] c_k_inc  = 5'b00100;
  localparam logic [4:0] c_k_dec  = 5'b01000;
  localparam logic [4:0] c_k_fmt  = 5'b10000;
  localparam logic [23:0] c_all   = 24'hFFFFFF;
  localparam logic [23:0] c_hm    = 24'hFFFF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  key = '0;
  logic [15:0] seg_data;
  logic [23:0] time_bcd;
  logic        tick_1s, set_mode, pm, alarm;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [23:0] mask;
    logic [23:0] exp;
  } exp_t;
  exp_t sb[$];

  rtc_clock_set #(.CLK_HZ(c_clk_hz), .RESET_HOUR(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .seg_data (seg_data),
    .time_bcd (time_bcd),
    .tick_1s  (tick_1s),
    .set_mode (set_mode),
    .pm       (pm),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] observe(input int sel);
    case (sel)
      0:       return time_bcd;
      1:       return {8'h00, seg_data};
      2:       return {23'd0, set_mode};
      3:       return {23'd0, pm};
      default: return {23'd0, alarm};
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sel) & e.mask, e.exp);
    end
  endtask

  task automatic expect_now(input string tag, input int sel, input logic [23:0] mask,
                            input logic [23:0] exp);
    sb.push_back('{tag, sel, mask, exp});
    drain();
  endtask

  // One key press: high for one cycle, then wait until the effect is registered.
  task automatic press(input logic [4:0] k, input string tag = "", input int sel = 0,
                       input logic [23:0] mask = 24'hFFFFFF, input logic [23:0] exp = '0);
    if (tag != "") sb.push_back('{tag, sel, mask, exp});
    key = k;
    @(negedge clk);
    key = '0;
    repeat (4) @(negedge clk);
    drain();
  endtask

  initial begin
    int n_blank, n_show, waited, ntick, first_tick, last_tick;

    repeat (3) @(negedge clk);
    expect_now("rst_time", 0, c_all, 24'h000000);
    expect_now("rst_seg",  1, c_all, 24'h000000);
    expect_now("rst_set",  2, c_all, 24'd0);
    expect_now("rst_pm",   3, c_all, 24'd0);
    expect_now("rst_alarm", 4, c_all, 24'd0);
    chk("rst_tick", {23'd0, tick_1s}, 24'd0);
    rst = 1'b0;

    press(c_k_mode, "enter_set", 2, c_all, 24'd1);
    press(c_k_dec, "hour_dec_wrap", 0, c_all, 24'h230000);

    n_blank = 0;
    n_show  = 0;
    for (int i = 0; i < c_clk_hz; i++) begin
      if (seg_data == 16'hFF00) n_blank++;
      if (seg_data == 16'h2300) n_show++;
      @(negedge clk);
    end
    chk("blink_blank", 24'(n_blank), 24'd5);
    chk("blink_show",  24'(n_show),  24'd5);

    press(c_k_inc | c_k_dec, "inc_dec_same", 0, c_all, 24'h230000);
    press(c_k_mode | c_k_inc, "mode_beats_inc", 0, c_all, 24'h230000);
    press(c_k_dec, "min_dec_wrap", 0, c_all, 24'h235900);
    press(c_k_mode);
    press(c_k_dec);
    press(c_k_dec, "sec_dec_58", 0, c_all, 24'h235958);
`ifdef ALARM_EN
    press(c_k_mode);
    press(c_k_mode);
`endif

    // Leave SET and time the first tick relative to the first RUN cycle.
    key = c_k_mode;
    @(negedge clk);
    key = '0;
    waited = 0;
    while (set_mode && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("run_entry", {23'd0, ~set_mode}, 24'd1);
    ntick = 0;
    first_tick = 0;
    last_tick = 0;
    for (int k = 1; k <= 22; k++) begin
      if (tick_1s) begin
        ntick++;
        if (first_tick == 0) first_tick = k;
        last_tick = k;
      end
      if (k == 1)  expect_now("hold_at_entry", 0, c_all, 24'h235958);
      if (k == 12) expect_now("sec_59",        0, c_all, 24'h235959);
      if (k == 22) expect_now("rollover",      0, c_all, 24'h000000);
      if (k < 22) @(negedge clk);
    end
    chk("first_tick", 24'(first_tick), 24'd10);
    chk("second_tick", 24'(last_tick), 24'd20);
    chk("tick_count", 24'(ntick), 24'd2);

    // Reset must act mid-cycle while editing minutes.
    press(c_k_mode);
    press(c_k_inc);
    press(c_k_mode);
    press(c_k_inc, "min_inc", 0, c_hm, 24'h010100);
    expect_now("in_set_min", 2, c_all, 24'd1);
    #2 rst = 1'b1;
    #1;
    expect_now("async_time", 0, c_all, 24'h000000);
    expect_now("async_set",  2, c_all, 24'd0);
    expect_now("async_seg",  1, c_all, 24'h000000);
    @(negedge clk);
    rst = 1'b0;
    repeat (11) @(negedge clk);
    expect_now("resume", 0, c_all, 24'h000001);

    press(c_k_mode);
    for (int i = 0; i < 13; i++) press(c_k_inc);
    press(c_k_mode);
    for (int i = 0; i < 5; i++) press(c_k_inc);
    press(c_k_mode);
    press(c_k_fmt, "seg_12h", 1, c_all, 24'h000105);
    expect_now("pm_13h", 3, c_all, 24'd1);
    expect_now("time_24h_kept", 0, c_hm, 24'h130500);
`ifdef ALARM_EN
    press(c_k_mode);
    press(c_k_mode);
`endif
    press(c_k_mode);
    press(c_k_page, "seg_page1", 1, 24'h00FF00, 24'h000500);
    press(c_k_inc, "run_ignores_inc", 0, c_hm, 24'h130500);

`ifdef ALARM_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) press(c_k_mode);
    press(c_k_inc);
    press(c_k_mode, "alarm_quiet", 4, c_all, 24'd0);
    waited = 0;
    while (!alarm && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    chk("alarm_rise", {23'd0, alarm}, 24'd1);
    @(negedge clk);
    expect_now("alarm_time", 0, c_all, 24'h000100);
    press(c_k_page, "alarm_clear", 4, c_all, 24'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
